maf_norm_stage: RTL and testbench

Normalization stage of the MAF datapath, on the consuming end of the leading-zero-anticipation interface. Takes the registered Sum/Carry pair, the anticipated leading-one vector F and the exponent, and forms the two's-complement sum and its magnitude. Left-normalizes the magnitude by the anticipated count and corrects the one-bit LZA error. Delivers the normalized mantissa and adjusted exponent to rounding through a 2-stage valid/ready pipeline.

---
 rtl/maf_norm_pkg.sv | 24 ++
 rtl/maf_norm_shift.sv | 32 +++
 rtl/maf_norm_stage.sv | 147 ++++++++++++++
 tb/tb_maf_norm_stage.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maf_norm_pkg.sv
// MAF normalization stage: shared widths, mode tags and
// the stage-1 payload bundle.
package maf_norm_pkg;

  localparam int MANT_W = 56;
  localparam int EXP_W  = 12;
  localparam int LZ_W   = 6;
  localparam int SUM_W  = 48;
  localparam int CAR_W  = 49;
  localparam int LZ_MAX = MANT_W - 1;

  localparam logic [2:0] CONT_SINGLE = 3'b000;
  localparam logic [2:0] CONT_DUAL   = 3'b001;
  localparam logic [2:0] CONT_HALF   = 3'b010;

  typedef struct packed {
    logic [MANT_W-1:0] r;
    logic [LZ_W:0]     lza;
    logic              sign;
    logic [EXP_W-1:0]  e;
    logic [2:0]        cont;
  } s1_t;

endpackage

// File: rtl/maf_norm_shift.sv
// Left normalizer: shift by the anticipated count, then
// absorb the one-bit LZA underestimate.
module maf_norm_shift
  import maf_norm_pkg::*;
(
  input  logic [MANT_W-1:0] i_r,
  input  logic [LZ_W:0]     i_lza,
  output logic [MANT_W-1:0] o_s,
  output logic [LZ_W-1:0]   o_lz,
  output logic              o_corr
);

  logic [LZ_W-1:0]   w_amt;
  logic [MANT_W-1:0] w_s0;

  always_comb begin
    w_amt = i_lza[LZ_W-1:0];
    if (i_lza > 7'(LZ_MAX)) begin
      w_amt = 6'(LZ_MAX);
    end
    w_s0   = i_r << w_amt;
    o_s    = w_s0;
    o_lz   = w_amt;
    o_corr = 1'b0;
    if (!w_s0[MANT_W-1]) begin
      o_s    = w_s0 << 1;
      o_lz   = w_amt + 6'd1;
      o_corr = 1'b1;
    end
  end

endmodule

// File: rtl/maf_norm_stage.sv
// MAF normalization: add/negate and leading-one encode in
// stage 1, shift/correct and exponent adjust in stage 2.
module maf_norm_stage
  import maf_norm_pkg::*;
#(
  parameter int MW = MANT_W,
  parameter int EW = EXP_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [47:0]   sum_in,
  input  logic [48:0]   carry_in,
  input  logic [MW-1:0] f_in,
  input  logic [EW-1:0] e_in,
  input  logic [2:0]    cont_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [MW-1:0] mant_out,
  output logic [EW-1:0] e_out,
  output logic [5:0]    lz_out,
  output logic          sign_out,
  output logic          zero_out,
  output logic          corr_out,
  output logic          uf_out,
  output logic [2:0]    cont_out
);

  logic [48:0]   w_r49;
  logic [48:0]   w_mag;
  logic [6:0]    w_lza;
  s1_t           w_s1_d;
  logic          w_s2_en;

  logic          r_s1_valid;
  s1_t           r_s1;

  logic [MW-1:0] w_s;
  logic [5:0]    w_lz;
  logic          w_corr;
  logic          w_zero;
  logic [EW:0]   w_diff;

  logic          r_s2_valid;
  logic [MW-1:0] r_mant;
  logic [EW-1:0] r_e;
  logic [5:0]    r_lz;
  logic          r_sign;
  logic          r_zero;
  logic          r_corr;
  logic          r_uf;
  logic [2:0]    r_cont;

  assign w_r49 = carry_in + {1'b0, sum_in};
  assign w_mag = w_r49[48] ? (~w_r49 + 49'd1) : w_r49;

  // Lowest set bit is scanned first so the highest one wins.
  always_comb begin
    w_lza = 7'(MW);
    for (int i = 0; i < MW; i++) begin
      if (f_in[i]) begin
        w_lza = 7'(MW - 1 - i);
      end
    end
  end

  always_comb begin
    w_s1_d      = '0;
    w_s1_d.r    = {w_mag, 7'b0};
    w_s1_d.lza  = w_lza;
    w_s1_d.sign = w_r49[48];
    w_s1_d.e    = e_in;
    w_s1_d.cont = cont_in;
  end

  assign w_s2_en  = !r_s2_valid || out_ready;
  assign in_ready = !r_s1_valid || w_s2_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1 <= w_s1_d;
      end
    end
  end

  maf_norm_shift u_shift (
    .i_r    (r_s1.r),
    .i_lza  (r_s1.lza),
    .o_s    (w_s),
    .o_lz   (w_lz),
    .o_corr (w_corr)
  );

  assign w_zero = (r_s1.r == '0);
  assign w_diff = {r_s1.e[EW-1], r_s1.e} - (EW+1)'(w_lz);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_mant     <= '0;
      r_e        <= '0;
      r_lz       <= '0;
      r_sign     <= 1'b0;
      r_zero     <= 1'b0;
      r_corr     <= 1'b0;
      r_uf       <= 1'b0;
      r_cont     <= '0;
    end else if (w_s2_en) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_sign <= r_s1.sign;
        r_cont <= r_s1.cont;
        r_zero <= w_zero;
        if (w_zero) begin
          r_mant <= '0;
          r_e    <= '0;
          r_lz   <= '0;
          r_corr <= 1'b0;
          r_uf   <= 1'b0;
        end else begin
          r_mant <= w_s;
          r_e    <= w_diff[EW-1:0];
          r_lz   <= w_lz;
          r_corr <= w_corr;
          r_uf   <= w_diff[EW] || (w_diff == '0);
        end
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign mant_out  = r_mant;
  assign e_out     = r_e;
  assign lz_out    = r_lz;
  assign sign_out  = r_sign;
  assign zero_out  = r_zero;
  assign corr_out  = r_corr;
  assign uf_out    = r_uf;
  assign cont_out  = r_cont;

endmodule

// File: tb/tb_maf_norm_stage.sv
// Bench for maf_norm_stage: directed vectors, stall, reset
// and random traffic against an arithmetic reference.
module tb_maf_norm_stage;

  typedef struct packed {
    logic [47:0] sum;
    logic [48:0] carry;
    logic [55:0] f;
    logic [11:0] e;
    logic [2:0]  cont;
  } beat_t;

  typedef struct packed {
    logic [55:0] mant;
    logic [11:0] e;
    logic [5:0]  lz;
    logic        sign;
    logic        zero;
    logic        corr;
    logic        uf;
    logic [2:0]  cont;
  } res_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] sum_in;
  logic [48:0] carry_in;
  logic [55:0] f_in;
  logic [11:0] e_in;
  logic [2:0]  cont_in;
  logic        out_valid;
  logic        out_ready;
  logic [55:0] mant_out;
  logic [11:0] e_out;
  logic [5:0]  lz_out;
  logic        sign_out;
  logic        zero_out;
  logic        corr_out;
  logic        uf_out;
  logic [2:0]  cont_out;

  maf_norm_stage dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum_in    (sum_in),
    .carry_in  (carry_in),
    .f_in      (f_in),
    .e_in      (e_in),
    .cont_in   (cont_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .mant_out  (mant_out),
    .e_out     (e_out),
    .lz_out    (lz_out),
    .sign_out  (sign_out),
    .zero_out  (zero_out),
    .corr_out  (corr_out),
    .uf_out    (uf_out),
    .cont_out  (cont_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_chk = 0;
  int    n_err = 0;
  int    n_out = 0;
  bit    saw_block;
  bit    hold_prev;
  res_t  prev_obs;
  res_t  last_obs;
  beat_t pend[$];
  res_t  exp_q[$];

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mag_r(logic [47:0] s,
                                        logic [48:0] c);
    logic [63:0] tot;
    logic [63:0] mag;
    tot = 64'(s) + 64'(c);
    tot = tot % (64'd1 << 49);
    mag = (tot >= (64'd1 << 48)) ? ((64'd1 << 49) - tot) : tot;
    return mag * 64'd128;
  endfunction

  function automatic int msb(logic [63:0] v);
    int h;
    h = -1;
    for (int i = 0; i < 64; i++) begin
      if (v[i]) h = i;
    end
    return h;
  endfunction

  function automatic res_t ref_model(beat_t b);
    res_t o;
    logic [63:0] tot;
    logic [63:0] r;
    int lz;
    int lza;
    int d;
    o = '0;
    tot = (64'(b.sum) + 64'(b.carry)) % (64'd1 << 49);
    o.sign = (tot >= (64'd1 << 48));
    o.cont = b.cont;
    r = mag_r(b.sum, b.carry);
    if (r == 0) begin
      o.zero = 1'b1;
      return o;
    end
    lz  = 55 - msb(r);
    lza = (msb(64'(b.f)) < 0) ? 56 : 55 - msb(64'(b.f));
    d   = int'($signed(b.e)) - lz;
    o.mant = 56'(r << lz);
    o.lz   = 6'(lz);
    o.corr = (lza != lz);
    o.e    = 12'(d);
    o.uf   = (d <= 0);
    return o;
  endfunction

  function automatic beat_t gen_beat();
    beat_t b;
    logic [63:0] r;
    logic [55:0] low;
    int lz;
    int lead;
    b.sum   = 48'({$urandom, $urandom} >> $urandom_range(0, 47));
    b.carry = 49'({$urandom, $urandom} >> $urandom_range(0, 48));
    if ($urandom_range(0, 9) == 0) begin
      b.carry = 49'((64'd1 << 49) - 64'(b.sum));
    end
    b.e = 12'($urandom);
    if ($urandom_range(0, 3) == 0) b.e = 12'($urandom_range(0, 60));
    b.cont = 3'($urandom_range(0, 2));
    r = mag_r(b.sum, b.carry);
    low = 56'({$urandom, $urandom, $urandom});
    if (r == 0) begin
      b.f = low;
    end else begin
      lz = 55 - msb(r);
      lead = 55 - lz;
      if (lz > 0 && $urandom_range(0, 1) == 1) lead++;
      b.f = (56'd1 << lead) | (low & ((56'd1 << lead) - 56'd1));
    end
    return b;
  endfunction

  function automatic res_t observed();
    return {mant_out, e_out, lz_out, sign_out, zero_out,
            corr_out, uf_out, cont_out};
  endfunction

  task automatic cycle(input bit ordy, input bit ival);
    res_t x;
    res_t o;
    @(negedge clk);
    out_ready = ordy;
    in_valid  = ival && (pend.size() > 0);
    if (pend.size() > 0) begin
      {sum_in, carry_in, f_in, e_in, cont_in} = pend[0];
    end
    #1;
    o = observed();
    if (hold_prev) chk("hold", o, prev_obs);
    if (!in_ready) saw_block = 1'b1;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", out_valid, 1'b0);
      end else begin
        x = exp_q.pop_front();
        chk("mant", o.mant, x.mant);
        chk("e_out", o.e, x.e);
        chk("lz", o.lz, x.lz);
        chk("sign", o.sign, x.sign);
        chk("zero", o.zero, x.zero);
        chk("corr", o.corr, x.corr);
        chk("uf", o.uf, x.uf);
        chk("cont", o.cont, x.cont);
        last_obs = o;
        n_out++;
      end
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(ref_model(pend.pop_front()));
    end
    hold_prev = out_valid && !out_ready;
    prev_obs  = o;
  endtask

  task automatic run_one(input beat_t b);
    int n0;
    int k;
    n0 = n_out;
    k = 0;
    pend.push_back(b);
    do begin
      cycle(1'b1, 1'b1);
      k++;
    end while (n_out == n0 && k < 10);
    chk("latency", k, 3);
  endtask

  initial begin
    int n0;
    int k;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    {sum_in, carry_in, f_in, e_in, cont_in} = '0;
    hold_prev = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_mant", mant_out, 56'd0);
    chk("rst_e", e_out, 12'd0);
    chk("rst_zero", zero_out, 1'b0);

    run_one('{sum: 48'd1, carry: 49'd0, f: 56'd1 << 7,
              e: 12'd100, cont: 3'd0});
    chk("d1_mant", last_obs.mant, 56'h80_0000_0000_0000);
    chk("d1_lz", last_obs.lz, 6'd48);
    chk("d1_e", last_obs.e, 12'd52);
    chk("d1_corr", last_obs.corr, 1'b0);
    chk("d1_sign", last_obs.sign, 1'b0);

    run_one('{sum: 48'd1, carry: 49'd0, f: 56'd1 << 8,
              e: 12'd100, cont: 3'd1});
    chk("d2_mant", last_obs.mant, 56'h80_0000_0000_0000);
    chk("d2_lz", last_obs.lz, 6'd48);
    chk("d2_e", last_obs.e, 12'd52);
    chk("d2_corr", last_obs.corr, 1'b1);

    // -2 as a 49-bit sum
    run_one('{sum: 48'hFFFF_FFFF_FFFF, carry: 49'h0_FFFF_FFFF_FFFF,
              f: 56'd1 << 8, e: 12'd60, cont: 3'd2});
    chk("d3_sign", last_obs.sign, 1'b1);
    chk("d3_mant", last_obs.mant, 56'h80_0000_0000_0000);
    chk("d3_lz", last_obs.lz, 6'd47);
    chk("d3_e", last_obs.e, 12'd13);

    run_one('{sum: 48'd0, carry: 49'd0, f: 56'd0,
              e: 12'd5, cont: 3'd0});
    chk("d4_zero", last_obs.zero, 1'b1);
    chk("d4_mant", last_obs.mant, 56'd0);
    chk("d4_e", last_obs.e, 12'd0);

    run_one('{sum: 48'd1 << 43, carry: 49'd0, f: 56'd1 << 50,
              e: 12'd3, cont: 3'd0});
    chk("d5_lz", last_obs.lz, 6'd5);
    chk("d5_uf", last_obs.uf, 1'b1);
    chk("d5_e", last_obs.e, 12'hFFE);
    chk("d5_mant", last_obs.mant, 56'h80_0000_0000_0000);

    n0 = n_out;
    saw_block = 1'b0;
    for (int i = 0; i < 6; i++) pend.push_back(gen_beat());
    k = 1;
    while (n_out < n0 + 6 && k < 40) begin
      cycle(!(k >= 2 && k <= 4), 1'b1);
      k++;
    end
    chk("stall_block", saw_block, 1'b1);
    chk("stall_count", n_out - n0, 6);

    pend.push_back(gen_beat());
    pend.push_back(gen_beat());
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    exp_q.delete();
    pend.delete();
    hold_prev = 1'b0;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b1);
    run_one(gen_beat());

    for (int i = 0; i < 400; i++) begin
      if (pend.size() == 0) pend.push_back(gen_beat());
      cycle($urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0);
    end
    pend.delete();
    k = 0;
    while (exp_q.size() > 0 && k < 20) begin
      cycle(1'b1, 1'b0);
      k++;
    end
    chk("drain_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
